forwarding_hazard_unit: RTL and testbench
=========================================

Name: forwarding_hazard_unit

Overview:
- Pipeline control block in the ID/EX boundary of the 5-stage RISC-V core.
- Tracks destination-register info of the instructions in EX and MEM, and produces the registered 2-bit selectors for the two EX-stage operand 3-to-1 muxes: 00 = register file, 01 = MEM/WB writeback, 10 = EX/MEM ALU result.
- Detects load-use hazards, issues a one-cycle stall and inserts a bubble into EX.
- Honours branch flush and keeps a saturating stall-cycle performance counter.

Parameters:
- NBits_Reg, 5, register index width.
- NBits_Cnt, 16, stall counter width.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- ID_Valid  input  1  ID holds a real instruction.
- ID_Rs1  input  NBits_Reg  source register 1 of the ID instruction.
- ID_Rs2  input  NBits_Reg  source register 2 of the ID instruction.
- ID_Rd  input  NBits_Reg  destination register of the ID instruction.
- ID_RegWrite  input  1  ID instruction writes Rd.
- ID_MemRead  input  1  ID instruction is a load.
- Flush  input  1  branch/jump taken in EX; squash the ID instruction.
- Forward_A_Sel  output  2  selector for the EX operand-A mux (registered).
- Forward_B_Sel  output  2  selector for the EX operand-B mux (registered).
- Stall  output  1  hold PC and IF/ID this cycle (combinational).
- EX_Bubble  output  1  EX holds a bubble; downstream zeroes its control signals (registered).
- Stall_Count  output  NBits_Cnt  saturating count of stall cycles.

Behaviour:
- Internal state:
  - EX slot: EX_Valid, EX_Rd, EX_RegWrite, EX_MemRead.
  - MEM slot: MEM_Valid, MEM_Rd, MEM_RegWrite.
- Reset (reset=0 at a rising edge):
  - All slots cleared (Valid=0).
  - Forward_A_Sel = Forward_B_Sel = 00; EX_Bubble = 1; Stall_Count = 0.
  - Stall reads 0 while reset=0.
- "Writes r" for a slot means: Valid & RegWrite & Rd != 0. x0 is never a forwarding or hazard source.
- Stall is combinational:
  - Stall = reset & !Flush & ID_Valid & EX slot writes r & EX_MemRead & (r == ID_Rs1 | r == ID_Rs2).
- Every rising edge with reset=1, the MEM slot always takes the old EX slot contents.
- EX slot update, in priority order:
  - Flush=1: EX slot takes a bubble (Valid=0, RegWrite=0, MemRead=0); both selectors = 00; EX_Bubble = 1. Flush has priority over Stall.
  - Stall=1: EX slot takes a bubble; selectors = 00; EX_Bubble = 1; ID is held by upstream, so the same ID inputs are re-evaluated next cycle.
  - Otherwise: EX slot takes the ID fields (Valid = ID_Valid); EX_Bubble = !ID_Valid. Selectors are computed per source s in {ID_Rs1, ID_Rs2} against the pre-edge slots:
    - 10 if the EX slot writes s;
    - else 01 if the MEM slot writes s;
    - else 00.
    - The EX slot wins when both slots match (youngest producer).
    - If ID_Valid=0, the selector is 00.
- Latency:
  - Selectors and EX_Bubble are valid in the cycle the instruction sits in EX, one edge after ID.
  - Stall is same-cycle.
- A load-use hazard costs exactly one stall cycle. On the retry the load sits in MEM and the consumer gets selector 01.
- Writers three or more ahead are not tracked; the register file handles the WB-to-ID write-before-read bypass.
- Stall_Count increments by 1 on each edge where Stall=1 and saturates at all-ones.
- Reset mid-stall: state clears immediately and Stall deasserts in the same cycle reset is low.

Test Plan:
- Reset: reset=0 for 2 cycles -> Forward_A_Sel=00, Forward_B_Sel=00, Stall=0, EX_Bubble=1, Stall_Count=0.
- EX forward: issue RegWrite Rd=5, then next cycle issue Rs1=5, Rs2=3 -> after that edge Forward_A_Sel=10, Forward_B_Sel=00, EX_Bubble=0.
- MEM forward and priority:
  - Writer Rd=5, then unrelated Rd=7, then Rs2=5 -> Forward_B_Sel=01.
  - Two consecutive writers Rd=6, then Rs1=Rs2=6 -> both selectors 10.
- Load-use: load Rd=8, then Rs1=8 -> Stall=1 for exactly one cycle; next edge EX_Bubble=1 and Stall_Count=1; following edge Forward_A_Sel=01.
- x0 and Flush:
  - Writer Rd=0, then Rs1=0 -> Forward_A_Sel=00.
  - Load Rd=9 with the consumer Rs1=9 in ID while Flush=1 -> Stall=0, EX_Bubble=1, selectors 00, Stall_Count unchanged.
- Saturation: with NBits_Cnt=4, force 20 stall cycles -> Stall_Count=15, with no wrap to 0.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - EX-stage operand forwarding selectors, load-use stall and bubble control
module forwarding_hazard_unit #(
  parameter int NBits_Reg = 5,
  parameter int NBits_Cnt = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ID_Valid,
  input  logic [NBits_Reg-1:0] ID_Rs1,
  input  logic [NBits_Reg-1:0] ID_Rs2,
  input  logic [NBits_Reg-1:0] ID_Rd,
  input  logic                 ID_RegWrite,
  input  logic                 ID_MemRead,
  input  logic                 Flush,
  output logic [1:0]           Forward_A_Sel,
  output logic [1:0]           Forward_B_Sel,
  output logic                 Stall,
  output logic                 EX_Bubble,
  output logic [NBits_Cnt-1:0] Stall_Count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  logic                 r_ex_valid;
  logic [NBits_Reg-1:0] r_ex_rd;
  logic                 r_ex_regwrite;
  logic                 r_ex_memread;
  logic                 r_mem_valid;
  logic [NBits_Reg-1:0] r_mem_rd;
  logic                 r_mem_regwrite;
  logic [1:0]           r_fwd_a;
  logic [1:0]           r_fwd_b;
  logic                 r_ex_bubble;
  logic [NBits_Cnt-1:0] r_stall_cnt;

  logic       w_ex_writes;
  logic       w_mem_writes;
  logic       w_stall;
  logic       w_squash;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  // x0 is hardwired zero, so a slot targeting it never produces a value
  assign w_ex_writes  = r_ex_valid & r_ex_regwrite & (r_ex_rd != '0);
  assign w_mem_writes = r_mem_valid & r_mem_regwrite & (r_mem_rd != '0);

  assign w_stall = reset & ~Flush & ID_Valid & w_ex_writes & r_ex_memread &
                   ((r_ex_rd == ID_Rs1) | (r_ex_rd == ID_Rs2));
  assign w_squash = Flush | w_stall;

  // Youngest producer wins: EX slot checked before MEM slot
  always_comb begin
    w_sel_a = SEL_RF;
    w_sel_b = SEL_RF;
    if (ID_Valid) begin
      if (w_ex_writes && (r_ex_rd == ID_Rs1)) begin
        w_sel_a = SEL_ALU;
      end else if (w_mem_writes && (r_mem_rd == ID_Rs1)) begin
        w_sel_a = SEL_WB;
      end
      if (w_ex_writes && (r_ex_rd == ID_Rs2)) begin
        w_sel_b = SEL_ALU;
      end else if (w_mem_writes && (r_mem_rd == ID_Rs2)) begin
        w_sel_b = SEL_WB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_fwd_a        <= SEL_RF;
      r_fwd_b        <= SEL_RF;
      r_ex_bubble    <= 1'b1;
    end else begin
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      if (w_squash) begin
        r_ex_valid    <= 1'b0;
        r_ex_rd       <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
        r_fwd_a       <= SEL_RF;
        r_fwd_b       <= SEL_RF;
        r_ex_bubble   <= 1'b1;
      end else begin
        r_ex_valid    <= ID_Valid;
        r_ex_rd       <= ID_Rd;
        r_ex_regwrite <= ID_RegWrite;
        r_ex_memread  <= ID_MemRead;
        r_fwd_a       <= w_sel_a;
        r_fwd_b       <= w_sel_b;
        r_ex_bubble   <= ~ID_Valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + NBits_Cnt'(1);
    end
  end

  assign Forward_A_Sel = r_fwd_a;
  assign Forward_B_Sel = r_fwd_b;
  assign Stall         = w_stall;
  assign EX_Bubble     = r_ex_bubble;
  assign Stall_Count   = r_stall_cnt;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb/tb_forwarding_hazard_unit.sv - self-checking bench for forwarding_hazard_unit
module tb_forwarding_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_regwrite, id_memread, flush;
  logic [1:0]  fwd_a, fwd_b, fwd_a4, fwd_b4;
  logic        stall, stall4, bubble, bubble4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  forwarding_hazard_unit u_dut (
    .clk(clk), .reset(reset), .ID_Valid(id_valid), .ID_Rs1(id_rs1), .ID_Rs2(id_rs2),
    .ID_Rd(id_rd), .ID_RegWrite(id_regwrite), .ID_MemRead(id_memread), .Flush(flush),
    .Forward_A_Sel(fwd_a), .Forward_B_Sel(fwd_b), .Stall(stall), .EX_Bubble(bubble),
    .Stall_Count(cnt16)
  );

  forwarding_hazard_unit #(.NBits_Reg(5), .NBits_Cnt(4)) u_dut4 (
    .clk(clk), .reset(reset), .ID_Valid(id_valid), .ID_Rs1(id_rs1), .ID_Rs2(id_rs2),
    .ID_Rd(id_rd), .ID_RegWrite(id_regwrite), .ID_MemRead(id_memread), .Flush(flush),
    .Forward_A_Sel(fwd_a4), .Forward_B_Sel(fwd_b4), .Stall(stall4), .EX_Bubble(bubble4),
    .Stall_Count(cnt4)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  // In-flight instructions, index 0 = youngest (in EX), index 1 = in MEM
  instr_t q[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     stalls_seen = 0;
  int     exp_a = 0, exp_b = 0, exp_bub = 1;
  logic   last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit produces(instr_t e, logic [4:0] r);
    return e.v && e.wr && e.rd != 5'd0 && e.rd == r;
  endfunction

  function automatic int pick_source(logic [4:0] rs);
    for (int age = 0; age < 2; age++)
      if (produces(q[age], rs)) return (age == 0) ? 2 : 1;
    return 0;
  endfunction

  task automatic apply(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic ld,
                       input logic fl, input logic rst);
    bit     exp_stall;
    instr_t nxt;
    reset = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_regwrite = rw; id_memread = ld; flush = fl;
    exp_stall = rst && !fl && v && q[0].ld &&
                (produces(q[0], rs1) || produces(q[0], rs2));
    #2;
    last_stall = stall;
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("stall4", 32'(stall4), 32'(exp_stall));
    @(posedge clk);
    #1;
    if (!rst) begin
      q = '{instr_t'(0), instr_t'(0)};
      exp_a = 0; exp_b = 0; exp_bub = 1; stalls_seen = 0;
    end else begin
      if (fl || exp_stall || !v) begin
        exp_a = 0; exp_b = 0;
      end else begin
        exp_a = pick_source(rs1); exp_b = pick_source(rs2);
      end
      exp_bub = (fl || exp_stall || !v) ? 1 : 0;
      nxt = (fl || exp_stall) ? instr_t'(0) : instr_t'{v, rd, rw, ld};
      if (exp_stall) stalls_seen++;
      q.push_front(nxt);
      void'(q.pop_back());
    end
    chk("fwd_a", 32'(fwd_a), 32'(exp_a));
    chk("fwd_b", 32'(fwd_b), 32'(exp_b));
    chk("bubble", 32'(bubble), 32'(exp_bub));
    chk("fwd_a4", 32'(fwd_a4), 32'(exp_a));
    chk("fwd_b4", 32'(fwd_b4), 32'(exp_b));
    chk("bubble4", 32'(bubble4), 32'(exp_bub));
    chk("cnt16", 32'(cnt16), 32'((stalls_seen > 65535) ? 65535 : stalls_seen));
    chk("cnt4", 32'(cnt4), 32'((stalls_seen > 15) ? 15 : stalls_seen));
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int cnt_before;
    q = '{instr_t'(0), instr_t'(0)};

    apply(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_a", 32'(fwd_a), 32'd0);
    chk("rst_b", 32'(fwd_b), 32'd0);
    chk("rst_stall", 32'(last_stall), 32'd0);
    chk("rst_bubble", 32'(bubble), 32'd1);
    chk("rst_cnt", 32'(cnt16), 32'd0);

    apply(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 5'd5, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("exfwd_a", 32'(fwd_a), 32'd2);
    chk("exfwd_b", 32'(fwd_b), 32'd0);
    chk("exfwd_bub", 32'(bubble), 32'd0);

    apply(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("memfwd_b", 32'(fwd_b), 32'd1);

    apply(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("prio_a", 32'(fwd_a), 32'd2);
    chk("prio_b", 32'(fwd_b), 32'd2);

    cnt_before = int'(cnt16);
    apply(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 5'd8, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_bubble", 32'(bubble), 32'd1);
    chk("lu_cnt", 32'(cnt16), 32'(cnt_before + 1));
    apply(1'b1, 5'd8, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("lu_retry_stall", 32'(last_stall), 32'd0);
    chk("lu_retry_a", 32'(fwd_a), 32'd1);

    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("x0_a", 32'(fwd_a), 32'd0);

    apply(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    cnt_before = int'(cnt16);
    apply(1'b1, 5'd9, 5'd9, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("fl_stall", 32'(last_stall), 32'd0);
    chk("fl_bubble", 32'(bubble), 32'd1);
    chk("fl_a", 32'(fwd_a), 32'd0);
    chk("fl_b", 32'(fwd_b), 32'd0);
    chk("fl_cnt", 32'(cnt16), 32'(cnt_before));

    // Stall asserted then reset drops in the same cycle
    apply(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 5'd12, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_stall", 32'(last_stall), 32'd0);

    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) != 0));
    end

    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      apply(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("sat_cnt4", 32'(cnt4), 32'd15);
    chk("sat_cnt16", 32'(cnt16), 32'd20);
    idle();
    chk("sat_hold4", 32'(cnt4), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
